// File: rtl/instr_loader.sv
// Boot-time loader: assembles big-endian words from a byte stream and writes them
// to instruction memory, then releases the CPU. Optional checksum: LOADER_CHECKSUM_EN.
module instr_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [15:0] words_loaded,
  output logic        done,
  output logic        cpu_run,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {HDR0, HDR1, DATA, DONE, ERR} state_t;
`endif

  localparam logic [16:0] MAXW = 17'(MAX_WORDS);

  state_t      state;
  logic [15:0] count;
  logic [1:0]  bidx;
  logic [23:0] part;
  logic [15:0] hcount;
  logic        xfer;
  logic        last;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  xsum;
`endif

  // Ready is a function of state, but reset must also block a transfer in its own cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      case (state)
        HDR0, HDR1, DATA: in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        CHK:              in_ready = 1'b1;
`endif
        default:          in_ready = 1'b0;
      endcase
    end
  end

  assign xfer   = in_valid & in_ready;
  assign hcount = {count[15:8], in_data};
  assign last   = (words_loaded == count - 16'd1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= HDR0;
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_BASE;
      mem_wdata    <= 32'h0;
      words_loaded <= 16'h0;
      done         <= 1'b0;
      cpu_run      <= 1'b0;
      error        <= 1'b0;
      count        <= 16'h0;
      bidx         <= 2'd0;
      part         <= 24'h0;
`ifdef LOADER_CHECKSUM_EN
      xsum         <= 8'h0;
`endif
    end else begin
      mem_we <= 1'b0;
      case (state)
        HDR0: if (xfer) begin
          count[15:8] <= in_data;
          state       <= HDR1;
        end
        HDR1: if (xfer) begin
          count[7:0] <= in_data;
          if ({1'b0, hcount} > MAXW) begin
            state <= ERR;
            error <= 1'b1;
          end else if (hcount == 16'h0) begin
`ifdef LOADER_CHECKSUM_EN
            state <= CHK;
`else
            state   <= DONE;
            done    <= 1'b1;
            cpu_run <= 1'b1;
`endif
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          xsum <= xsum ^ in_data;
`endif
          bidx <= bidx + 2'd1;
          part <= {part[15:0], in_data};
          if (bidx == 2'd3) begin
            mem_we       <= 1'b1;
            mem_addr     <= ADDR_BASE + {14'h0, words_loaded, 2'b00};
            mem_wdata    <= {part, in_data};
            words_loaded <= words_loaded + 16'd1;
            // done follows from the DONE state one cycle later, never alongside mem_we
            if (last) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: if (xfer) begin
          if (in_data == xsum) begin
            state   <= DONE;
            done    <= 1'b1;
            cpu_run <= 1'b1;
          end else begin
            state <= ERR;
            error <= 1'b1;
          end
        end
`endif
        DONE: begin
          done    <= 1'b1;
          cpu_run <= 1'b1;
        end
        ERR: begin
          error   <= 1'b1;
          done    <= 1'b0;
          cpu_run <= 1'b0;
        end
        default: state <= HDR0;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized bench for instr_loader: two instances (base 0/max 256, base 0x40/max 4)
// share one byte stream; a queue-based image model predicts writes, status and timing.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready[2], mem_we[2], done[2], cpu_run[2], error[2];
  logic [31:0] mem_addr[2], mem_wdata[2];
  logic [15:0] words_loaded[2];

  always #5 clk = ~clk;

  instr_loader #(.ADDR_BASE(32'h0), .MAX_WORDS(256)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[0]),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .words_loaded(words_loaded[0]), .done(done[0]), .cpu_run(cpu_run[0]), .error(error[0]));

  instr_loader #(.ADDR_BASE(32'h40), .MAX_WORDS(4)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready[1]),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .words_loaded(words_loaded[1]), .done(done[1]), .cpu_run(cpu_run[1]), .error(error[1]));

  int n_chk = 0, n_pass = 0;
  int ncyc = 0;

  // observed
  logic [31:0] wa[2][16], wd[2][16];
  int          wc[2][16], nw[2], done_cyc[2], err_cyc[2];
  // expected
  logic [7:0]  img[$];
  int          acc_cyc[64];
  logic [31:0] e_addr[2][16], e_data[2][16];
  int          e_nw[2], e_nacc[2], e_cnt[2];
  logic [15:0] e_wl[2];
  logic        e_err[2];

  function automatic logic [31:0] base(input int k);
    return (k == 1) ? 32'h40 : 32'h0;
  endfunction

  function automatic int maxw(input int k);
    return (k == 1) ? 4 : 256;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  initial forever begin
    @(negedge clk);
    ncyc++;
    for (int k = 0; k < 2; k++) begin
      if (mem_we[k]) begin
        if (nw[k] < 16) begin
          wa[k][nw[k]] = mem_addr[k];
          wd[k][nw[k]] = mem_wdata[k];
          wc[k][nw[k]] = ncyc;
        end
        nw[k]++;
      end
      if (done[k] && done_cyc[k] < 0) done_cyc[k] = ncyc;
      if (error[k] && err_cyc[k] < 0) err_cyc[k] = ncyc;
    end
  end

  // Image rules: 2-byte count, 4*count data bytes, optional XOR checksum byte.
  task automatic model(input int k);
    logic [15:0] c;
    logic [7:0]  x;
    c = {img[0], img[1]};
    e_cnt[k] = int'(c);
    e_nw[k] = 0; e_err[k] = 1'b0; e_wl[k] = 16'h0;
    if (int'(c) > maxw(k)) begin
      e_err[k] = 1'b1;
      e_nacc[k] = 2;
    end else begin
      e_nw[k] = int'(c);
      e_wl[k] = c;
      e_nacc[k] = 2 + 4 * int'(c);
      for (int w = 0; w < int'(c) && w < 16; w++) begin
        e_addr[k][w] = base(k) + 32'(4 * w);
        e_data[k][w] = {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]};
      end
`ifdef LOADER_CHECKSUM_EN
      x = 8'h0;
      for (int i = 2; i < e_nacc[k]; i++) x = x ^ img[i];
      e_err[k] = (img[e_nacc[k]] != x);
      e_nacc[k]++;
`else
      x = 8'h0;
`endif
    end
  endtask

  task automatic finish_img(input bit bad);
    logic [7:0] x;
    x = 8'h0;
`ifdef LOADER_CHECKSUM_EN
    for (int i = 2; i < img.size(); i++) x = x ^ img[i];
    img.push_back(bad ? (x ^ 8'h01) : x);
`else
    if (bad) x = 8'h0;
`endif
    img.push_back(8'($urandom));
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b1; in_data = 8'($urandom);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk($sformatf("in_ready_in_rst[%0d]", k), 32'(in_ready[k]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_we[%0d]", k), 32'(mem_we[k]), 32'd0);
      chk($sformatf("rst_addr[%0d]", k), mem_addr[k], base(k));
      chk($sformatf("rst_wdata[%0d]", k), mem_wdata[k], 32'h0);
      chk($sformatf("rst_wl[%0d]", k), 32'(words_loaded[k]), 32'd0);
      chk($sformatf("rst_flags[%0d]", k), {29'h0, done[k], cpu_run[k], error[k]}, 32'd0);
      chk($sformatf("rst_ready[%0d]", k), 32'(in_ready[k]), 32'd1);
      nw[k] = 0; done_cyc[k] = -1; err_cyc[k] = -1;
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input int gmax);
    for (int i = 0; i < img.size(); i++) begin
      repeat ($urandom_range(0, gmax)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1; in_data = img[i];
      @(negedge clk);
      for (int k = 0; k < 2; k++)
        chk($sformatf("ready_b%0d[%0d]", i, k), 32'(in_ready[k]), 32'(i < e_nacc[k]));
      @(posedge clk); #1;
      acc_cyc[i] = ncyc + 1;
      in_valid = 1'b0;
    end
  endtask

  task automatic eval(input int k);
    int ed;
    chk($sformatf("nwrites[%0d]", k), 32'(nw[k]), 32'(e_nw[k]));
    for (int w = 0; w < e_nw[k] && w < nw[k] && w < 16; w++) begin
      chk($sformatf("waddr%0d[%0d]", w, k), wa[k][w], e_addr[k][w]);
      chk($sformatf("wdata%0d[%0d]", w, k), wd[k][w], e_data[k][w]);
      chk($sformatf("wcyc%0d[%0d]", w, k), 32'(wc[k][w]), 32'(acc_cyc[5+4*w]));
    end
    chk($sformatf("words_loaded[%0d]", k), 32'(words_loaded[k]), 32'(e_wl[k]));
    chk($sformatf("done[%0d]", k), 32'(done[k]), 32'(!e_err[k]));
    chk($sformatf("cpu_run[%0d]", k), 32'(cpu_run[k]), 32'(!e_err[k]));
    chk($sformatf("error[%0d]", k), 32'(error[k]), 32'(e_err[k]));
    chk($sformatf("ready_end[%0d]", k), 32'(in_ready[k]), 32'd0);
    if (e_err[k]) begin
      chk($sformatf("err_cyc[%0d]", k), 32'(err_cyc[k]), 32'(acc_cyc[e_nacc[k]-1]));
      chk($sformatf("never_done[%0d]", k), 32'(done_cyc[k]), 32'hFFFF_FFFF);
    end else begin
`ifdef LOADER_CHECKSUM_EN
      ed = acc_cyc[e_nacc[k]-1];
`else
      ed = (e_cnt[k] == 0) ? acc_cyc[1] : acc_cyc[e_nacc[k]-1] + 1;
`endif
      chk($sformatf("done_cyc[%0d]", k), 32'(done_cyc[k]), 32'(ed));
    end
  endtask

  task automatic run(input int gmax);
    reset_dut();
    model(0); model(1);
    send(gmax);
    repeat (6) @(posedge clk);
    #1;
    eval(0); eval(1);
  endtask

  task automatic rand_img(input int cnt);
    img = {};
    img.push_back(8'(cnt >> 8)); img.push_back(8'(cnt));
    for (int i = 0; i < 4 * cnt; i++) img.push_back(8'($urandom));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h0;
    for (int k = 0; k < 2; k++) begin nw[k] = 0; done_cyc[k] = -1; err_cyc[k] = -1; end
    repeat (2) @(posedge clk);
    #1;
    // basic load, back-to-back then gapped
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    finish_img(1'b0); run(0);
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    finish_img(1'b0); run(3);
    // count 5: fine for the 256-word instance, oversize for the 4-word one
    rand_img(5); finish_img(1'b0); run(1);
    // oversize for both instances
    img = '{8'h01, 8'h01, 8'h11, 8'h22, 8'h33}; run(0);
    // reset mid-load after the 6th byte, then a fresh one-word image
    reset_dut();
    img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05};
    e_nacc[0] = 99; e_nacc[1] = 99;
    send(0);
    img = '{8'h00, 8'h01, 8'h8C, 8'h01, 8'h00, 8'h00};
    finish_img(1'b0); run(0);
    // empty image
    rand_img(0); finish_img(1'b0); run(0);
`ifdef LOADER_CHECKSUM_EN
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08, 8'h5A}; run(0);
    img = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09, 8'h5A}; run(0);
`endif
    for (int t = 0; t < 30; t++) begin
      rand_img($urandom_range(0, 6));
      finish_img($urandom_range(0, 3) == 0);
      run($urandom_range(0, 3));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
